// File: rtl/cnfg_pkg.sv
// Shared definitions for the configuration shift-register driver.
package cnfg_pkg;

   localparam int unsigned CNFG_SIZE = 8;
   localparam int unsigned CNFG_DIV  = 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SHIFT = 3'd1;
   localparam logic [2:0] ST_GAP   = 3'd2;
   localparam logic [2:0] ST_LOAD  = 3'd3;
   localparam logic [2:0] ST_FIN   = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      GAP   = ST_GAP,
      LOAD  = ST_LOAD,
      FIN   = ST_FIN
   } state_t;

endpackage

// File: rtl/cnfg_phase_cnt.sv
// Half-period counter: tick_c marks the last system cycle of each DIV-cycle phase.
module cnfg_phase_cnt
   import cnfg_pkg::*;
#(
   parameter int unsigned DIV = CNFG_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned    CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick_c = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/cnfg_sr_driver.sv
// Drives the chip configuration shift register (MSB first) and reads back its
// previous contents while shifting, then pulses the load strobe.
module cnfg_sr_driver
   import cnfg_pkg::*;
#(
   parameter int unsigned SIZE = CNFG_SIZE,
   parameter int unsigned DIV  = CNFG_DIV
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] data_in,
   input  logic            sr_so,
   output logic            sr_clk,
   output logic            sr_si,
   output logic            sr_ld,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] readback
);

   localparam int unsigned   BW       = $clog2(SIZE + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

   state_t          state, state_nx;
   // The MSB goes straight to sr_si on acceptance, so only the remaining bits are kept.
   logic [SIZE-2:0] shadow, shadow_nx;
   logic [SIZE-1:0] readback_nx;
   logic [BW-1:0]   bit_cnt, bit_cnt_nx;
   logic            sr_clk_nx, sr_si_nx, sr_ld_nx, busy_nx, done_nx;
   logic            tick_c, phase_clr_c;

   assign phase_clr_c = (state == IDLE) || (state == FIN);

   cnfg_phase_cnt #(.DIV(DIV)) u_phase (
      .clk    (clk),
      .rst    (rst),
      .clr    (phase_clr_c),
      .tick_c (tick_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shadow   <= '0;
         readback <= '0;
         bit_cnt  <= '0;
         sr_clk   <= 1'b0;
         sr_si    <= 1'b0;
         sr_ld    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         shadow   <= shadow_nx;
         readback <= readback_nx;
         bit_cnt  <= bit_cnt_nx;
         sr_clk   <= sr_clk_nx;
         sr_si    <= sr_si_nx;
         sr_ld    <= sr_ld_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      shadow_nx   = shadow;
      readback_nx = readback;
      bit_cnt_nx  = bit_cnt;
      sr_clk_nx   = sr_clk;
      sr_si_nx    = sr_si;
      sr_ld_nx    = 1'b0;
      done_nx     = 1'b0;

      case (state)
         IDLE: begin
            sr_si_nx = 1'b0;
            if (start) begin
               state_nx    = SHIFT;
               shadow_nx   = data_in[SIZE-2:0];
               readback_nx = '0;
               bit_cnt_nx  = '0;
               sr_clk_nx   = 1'b0;
               sr_si_nx    = data_in[SIZE-1];
            end
         end
         SHIFT: begin
            if (tick_c) begin
               if (!sr_clk) begin
                  // Sample before the chip sees the rising edge and shifts.
                  sr_clk_nx   = 1'b1;
                  readback_nx = {readback[SIZE-2:0], sr_so};
               end else begin
                  sr_clk_nx = 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     state_nx   = GAP;
                     bit_cnt_nx = '0;
                  end else begin
                     bit_cnt_nx = bit_cnt + BW'(1);
                     sr_si_nx   = shadow[SIZE-2];
                     shadow_nx  = shadow << 1;
                  end
               end
            end
         end
         GAP: begin
            if (tick_c) begin
               state_nx = LOAD;
               sr_ld_nx = 1'b1;
            end
         end
         LOAD: begin
            sr_ld_nx = 1'b1;
            if (tick_c) begin
               state_nx = FIN;
               sr_ld_nx = 1'b0;
               done_nx  = 1'b1;
            end
         end
         FIN: begin
            state_nx = IDLE;
            sr_si_nx = 1'b0;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx == SHIFT) || (state_nx == GAP) || (state_nx == LOAD);
   end

endmodule

// File: tb/tb_cnfg_sr_driver.sv
// Directed bench for cnfg_sr_driver with behavioural chip shift-register/latch models.
module tb_cnfg_sr_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       sr_so, sr_clk, sr_si, sr_ld, busy, done;
   logic [7:0] readback;

   logic       start2 = 1'b0;
   logic [1:0] data2 = 2'b00;
   logic       so2, clk2, si2, ld2, busy2, done2;
   logic [1:0] rb2;

   int errors = 0;
   int checks = 0;
   int rise_cnt = 0;
   int rise2 = 0;
   int ld_cnt = 0;
   int done_cnt = 0;
   logic si_prev = 1'b0;
   logic si2_prev = 1'b0;

   logic [7:0] chip_sr = 8'h3C;
   logic [7:0] latch = 8'h00;
   logic [1:0] chip2 = 2'b01;
   logic [1:0] latch2 = 2'b00;

   always #5 clk = ~clk;

   cnfg_sr_driver u_dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .sr_so(sr_so),
      .sr_clk(sr_clk), .sr_si(sr_si), .sr_ld(sr_ld), .busy(busy), .done(done),
      .readback(readback)
   );

   cnfg_sr_driver #(.SIZE(2), .DIV(1)) u_min (
      .clk(clk), .rst(rst), .start(start2), .data_in(data2), .sr_so(so2),
      .sr_clk(clk2), .sr_si(si2), .sr_ld(ld2), .busy(busy2), .done(done2),
      .readback(rb2)
   );

   // Chip models: shift on sr_clk rise, latch value frozen when sr_ld falls.
   assign sr_so = chip_sr[7];
   assign so2   = chip2[1];
   always @(posedge sr_clk) chip_sr <= {chip_sr[6:0], sr_si};
   always @(negedge sr_ld)  latch   <= chip_sr;
   always @(posedge clk2)   chip2   <= {chip2[0], si2};
   always @(negedge ld2)    latch2  <= chip2;

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b1;
      data_in = 8'hFF;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      checks++;
      if ({sr_clk, sr_si, sr_ld, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=00000", {sr_clk, sr_si, sr_ld, busy, done});
      end
      checks++;
      if (readback !== 8'h00) begin
         errors++;
         $display("FAIL reset_readback got=%h want=00", readback);
      end
      checks++;
      if ({clk2, si2, ld2, busy2, done2, rb2} !== 7'b0) begin
         errors++;
         $display("FAIL reset_min got=%b want=0000000", {clk2, si2, ld2, busy2, done2, rb2});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_with_rst busy=%b want=0", busy);
      end
   endtask

   task automatic write_word(input logic [7:0] d, output int n);
      @(negedge clk);
      start = 1'b1;
      data_in = d;
      rise_cnt = 0;
      ld_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise busy=%b want=1", busy);
      end
      wait_done(n);
   endtask

   task automatic test_basic();
      int n;
      write_word(8'hA5, n);
      checks++;
      if (n !== 36) begin
         errors++;
         $display("FAIL basic_latency got=%0d want=36", n);
      end
      checks++;
      if (readback !== 8'h3C) begin
         errors++;
         $display("FAIL basic_readback got=%h want=3c", readback);
      end
      checks++;
      if (latch !== 8'hA5 || ld_cnt !== 1) begin
         errors++;
         $display("FAIL basic_latch got=%h ld=%0d want=a5 ld=1", latch, ld_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_at_done busy=%b want=0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      write_word(8'h5A, n);
      checks++;
      if (n !== 36) begin
         errors++;
         $display("FAIL b2b_latency got=%0d want=36", n);
      end
      checks++;
      if (readback !== 8'hA5) begin
         errors++;
         $display("FAIL b2b_readback got=%h want=a5", readback);
      end
      checks++;
      if (latch !== 8'h5A) begin
         errors++;
         $display("FAIL b2b_latch got=%h want=5a", latch);
      end
      checks++;
      if (rise_cnt !== 8) begin
         errors++;
         $display("FAIL b2b_rises got=%0d want=8", rise_cnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sr_si !== 1'b0 || readback !== 8'hA5) begin
         errors++;
         $display("FAIL after_done done=%b si=%b rb=%h want 0 0 a5", done, sr_si, readback);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      @(negedge clk);
      start = 1'b1;
      data_in = 8'h81;
      rise_cnt = 0;
      ld_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (rise_cnt < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({sr_clk, sr_si, sr_ld, busy, done} !== 5'b0 || readback !== 8'h00) begin
         errors++;
         $display("FAIL abort_outputs ctrl=%b rb=%h want 00000 00",
                  {sr_clk, sr_si, sr_ld, busy, done}, readback);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (latch !== 8'h5A || ld_cnt !== 0 || rise_cnt !== 3) begin
         errors++;
         $display("FAIL abort_latch latch=%h ld=%0d rises=%0d want 5a 0 3", latch, ld_cnt, rise_cnt);
      end
   endtask

   task automatic test_start_busy();
      int n;
      @(negedge clk);
      start = 1'b1;
      data_in = 8'hC3;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      repeat (10) @(negedge clk);
      start = 1'b1;
      data_in = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      repeat (40) @(negedge clk);
      checks++;
      if (latch !== 8'hC3) begin
         errors++;
         $display("FAIL busy_start_latch got=%h want=c3", latch);
      end
      // Chip held 5A shifted by the aborted bits 1,0,0.
      checks++;
      if (readback !== 8'hD4) begin
         errors++;
         $display("FAIL busy_start_readback got=%h want=d4", readback);
      end
      checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_done_count got=%0d busy=%b want=1 0", done_cnt, busy);
      end
   endtask

   task automatic test_min_params();
      int n;
      @(negedge clk);
      start2 = 1'b1;
      data2 = 2'b10;
      rise2 = 0;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (done2 !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL min_latency got=%0d want=6", n);
      end
      checks++;
      if (latch2 !== 2'b10 || rb2 !== 2'b01) begin
         errors++;
         $display("FAIL min_data latch=%b rb=%b want 10 01", latch2, rb2);
      end
      checks++;
      if (rise2 !== 2) begin
         errors++;
         $display("FAIL min_rises got=%0d want=2", rise2);
      end
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (sr_clk === 1'b1 || sr_ld === 1'b1) begin
               checks++;
               if (sr_clk === 1'b1 && sr_ld === 1'b1) begin
                  errors++;
                  $display("FAIL proto_ld_clk sr_clk=%b sr_ld=%b want not both 1", sr_clk, sr_ld);
               end
            end
            if (sr_clk === 1'b1) begin
               checks++;
               if (sr_si !== si_prev) begin
                  errors++;
                  $display("FAIL proto_si_stable got=%b want=%b", sr_si, si_prev);
               end
            end
            if (clk2 === 1'b1) begin
               checks++;
               if (si2 !== si2_prev || ld2 === 1'b1) begin
                  errors++;
                  $display("FAIL proto_min si=%b want=%b ld=%b", si2, si2_prev, ld2);
               end
            end
            si_prev  = sr_si;
            si2_prev = si2;
            if (done === 1'b1) done_cnt++;
         end
         forever begin
            @(posedge sr_clk);
            rise_cnt++;
         end
         forever begin
            @(posedge clk2);
            rise2++;
         end
         forever begin
            @(posedge sr_ld);
            ld_cnt++;
         end
      join_none

      test_reset();
      test_basic();
      test_back_to_back();
      test_mid_reset();
      test_start_busy();
      test_min_params();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cnfg_sr_driver.md
# cnfg_sr_driver

Master-side driver for the chip's serial configuration shift register. It takes a SIZE-bit parallel word from the DAQ register file and generates the slow shift clock, serial data and load strobe that the on-chip configuration register consumes. While shifting, it captures the register's serial output, so the previously loaded configuration is read back for verification. It sits in the FPGA firmware between the configuration register file and the chip configuration pins.

## Interface
- SIZE, 8, number of configuration bits in the chip register (≥2)
- DIV, 2, system-clock cycles per half period of sr_clk (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only when busy=0
- data_in  in  SIZE  configuration word; sampled on the accepting edge
- sr_so  in  1  serial output of the chip register
- sr_clk  out  1  shift clock to the chip
- sr_si  out  1  serial data to the chip
- sr_ld  out  1  load strobe to the chip (transparent-latch enable)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of sequence
- readback  out  SIZE  prior chip register contents; valid when done=1, held until next start

## Operation
- The clock and reset ports are clk and rst, matching the rest of the codebase. There is one clock domain, and reset is synchronous and active-high.
- Reset values: sr_clk=0, sr_si=0, sr_ld=0, busy=0, done=0, readback=0. The FSM enters IDLE.
- FSM states:
  - IDLE: on start, capture data_in into a shadow register, clear readback, go to SHIFT.
  - SHIFT: run SIZE bit periods, then go to GAP.
  - GAP: hold DIV cycles with sr_clk=0 and sr_ld=0, then go to LOAD.
  - LOAD: hold sr_ld=1 for DIV cycles, then go to FIN.
  - FIN: assert done for one cycle, then go to IDLE.
- Bit order is MSB first. Bit k (k=0..SIZE-1) drives sr_si=data[SIZE-1-k]. After SIZE rising edges the chip register holds data exactly.
- Each bit period is DIV cycles with sr_clk=0 followed by DIV cycles with sr_clk=1.
  - sr_si changes only at the start of a low phase.
  - sr_si stays stable through the following rising edge.
- readback capture:
  - On the system edge that sets sr_clk 0→1, sample sr_so into readback LSB and shift readback left by one.
  - This catches the chip output before the chip shifts. After SIZE bits, readback equals the chip's old contents, MSB first.
- start while busy=1 is ignored. start in the same cycle as rst is ignored.
- Reset mid-sequence aborts immediately and all outputs return to reset values.
  - sr_ld is never asserted for an aborted sequence, so the chip latch keeps its old value.
  - The chip shift register may hold partial data; this is allowed.
- sr_ld and sr_clk are never high together. sr_si is held at the last bit during GAP and LOAD, and returns to 0 in IDLE.

## Timing
- Start accepted at edge t0:
  - busy=1 from t0+1.
  - The first low phase begins at t0+1.
- SHIFT lasts 2·DIV·SIZE cycles. GAP lasts DIV cycles. LOAD lasts DIV cycles.
- done=1 in exactly one cycle, 2·DIV·(SIZE+1) cycles after busy rises.
  - busy drops in the same cycle that done is high.
  - A new start is accepted in the cycle after done.
- sr_clk has exactly SIZE rising edges per sequence with a 50 % duty cycle.
- Counter widths:
  - Bit counter: $clog2(SIZE+1).
  - Phase counter: $clog2(DIV+1).
  - No wrap is permitted. Counters reset on each state entry.

## Structure
- Shared package cnfg_pkg holds:
  - the FSM state encoding (IDLE, SHIFT, GAP, LOAD, FIN) as localparams;
  - the default SIZE and DIV.
- One sub-module, cnfg_phase_cnt, is a DIV-cycle phase counter producing a tick at the end of each half period. It is reused by SHIFT, GAP and LOAD.
- The top level holds the FSM, the shadow register, the bit counter and the readback shift register.

## Test plan
- Basic write and readback:
  - Setup: SIZE=8, DIV=2, behavioural chip register model preloaded 0x3C, data_in=0xA5.
  - Required: model latch = 0xA5 after sr_ld falls; readback=0xA5's predecessor 0x3C at done; done exactly 36 cycles after busy rises.
- Back-to-back writes:
  - Stimulus: write 0x5A immediately after the previous done.
  - Required: readback=0xA5, latch=0x5A, and exactly 8 sr_clk rising edges counted.
- Mid-shift reset:
  - Stimulus: assert rst after the 3rd sr_clk rising edge.
  - Required: all outputs 0 next cycle, no sr_ld pulse, latch still 0x5A.
- start while busy:
  - Stimulus: pulse start with data_in=0xFF mid-SHIFT.
  - Required: ignored; the sequence completes with the original word and only one done pulse.
- Minimum parameters:
  - Setup: SIZE=2, DIV=1, data=2'b10.
  - Required: done 6 cycles after busy, latch=2'b10, and sr_si stable across every sr_clk rising edge.
- Protocol checkers (run in all scenarios):
  - sr_ld and sr_clk are never high together.
  - sr_si never changes while sr_clk=1.
